// File: rtl/countones_pkg.sv
// Shared types and helpers for the countones family (countones, countones_gen).
package countones_pkg;

   typedef enum logic [0:0] {
      eIDLE  = 1'b0,
      eSHIFT = 1'b1
   } countones_gen_state_e;

   // Width needed to hold a population count of 0..width inclusive.
   function automatic int count_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/countones_gen_ctr.sv
// Saturating up-counter with synchronous clear (priority) and enable; holds the bit index.
module countones_gen_ctr
   import countones_pkg::*;
#(
   parameter int width_p = 4,
   parameter int max_p   = 7
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clear_i,
   input  logic               en_i,
   output logic [width_p-1:0] count_o
);

   localparam logic [width_p-1:0] max_c = width_p'(max_p);

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_o <= '0;
      end else if (clear_i) begin
         count_o <= '0;
      end else if (en_i && (count_o != max_c)) begin
         count_o <= count_o + 1'b1;
      end
   end

endmodule

// File: rtl/countones_gen.sv
// Serialises a population count into a width_p-bit thermometer word, LSB first.
// Optional COUNTONES_GEN_LAST_EN adds last_o, high on the final bit of each word.
module countones_gen
   import countones_pkg::*;
#(
   parameter int width_p = 8
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic                                  valid_i,
   input  logic [countones_pkg::count_width(width_p)-1:0] count_i,
   output logic                                  ready_o,
   output logic                                  valid_o,
   output logic                                  bit_o,
   input  logic                                  yumi_i
`ifdef COUNTONES_GEN_LAST_EN
   ,
   output logic                                  last_o
`endif
);

   localparam int count_width_lp = count_width(width_p);
   localparam logic [count_width_lp-1:0] width_c = count_width_lp'(width_p);
   localparam logic [count_width_lp-1:0] last_c  = count_width_lp'(width_p - 1);

   countones_gen_state_e        state_r, state_n;
   logic [count_width_lp-1:0]   count_r;
   logic [count_width_lp-1:0]   count_sat;
   logic [count_width_lp-1:0]   index;
   logic                        load;
   logic                        ctr_clear;
   logic                        ctr_en;
   logic                        last_bit;

   assign count_sat = (count_i > width_c) ? width_c : count_i;
   assign last_bit  = (index == last_c);

   countones_gen_ctr #(
      .width_p (count_width_lp),
      .max_p   (width_p - 1)
   ) u_ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (ctr_clear),
      .en_i    (ctr_en),
      .count_o (index)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= eIDLE;
         count_r <= '0;
      end else begin
         state_r <= state_n;
         if (load) begin
            count_r <= count_sat;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      state_n   = state_r;
      load      = 1'b0;
      ctr_clear = 1'b1;
      ctr_en    = 1'b0;
      ready_o   = 1'b0;
      valid_o   = 1'b0;
      bit_o     = 1'b0;
      case (state_r)
         eIDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               load    = 1'b1;
               state_n = eSHIFT;
            end
         end
         eSHIFT: begin
            valid_o   = 1'b1;
            bit_o     = (index < count_r);
            ctr_en    = yumi_i;
            ctr_clear = yumi_i && last_bit;
            if (yumi_i && last_bit) begin
               state_n = eIDLE;
            end
         end
         default: state_n = eIDLE;
      endcase
   end

`ifdef COUNTONES_GEN_LAST_EN
   assign last_o = valid_o && last_bit;
`endif

`ifndef SYNTHESIS
   // Ones emitted so far in the current word, for the per-word total check.
   logic [count_width_lp-1:0] ones_r;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ones_r <= '0;
      end else if (state_r == eIDLE) begin
         ones_r <= '0;
      end else if (yumi_i) begin
         ones_r <= ones_r + count_width_lp'(bit_o);
      end
   end

   a_yumi_valid : assert property (@(posedge clk_i) disable iff (reset_i)
      yumi_i |-> valid_o);

   a_index_range : assert property (@(posedge clk_i) disable iff (reset_i)
      (state_r == eSHIFT) |-> (index < width_c));

   a_ones_total : assert property (@(posedge clk_i) disable iff (reset_i)
      (state_r == eSHIFT && yumi_i && last_bit) |->
         ((ones_r + count_width_lp'(bit_o)) == count_r));
`endif

endmodule

// File: tb/tb_countones_gen.sv
// Self-checking bench for countones_gen: queue-based word model, directed cases, random traffic.
module tb_countones_gen;

   localparam int W  = 8;
   localparam int CW = $clog2(W) + 1;

   logic          clk = 1'b0;
   logic          reset_i;
   logic          valid_i;
   logic [CW-1:0] count_i;
   logic          ready_o;
   logic          valid_o;
   logic          bit_o;
   logic          yumi_i;
`ifdef COUNTONES_GEN_LAST_EN
   logic          last_o;
`endif

   countones_gen #(.width_p(W)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .valid_i (valid_i),
      .count_i (count_i),
      .ready_o (ready_o),
      .valid_o (valid_o),
      .bit_o   (bit_o),
      .yumi_i  (yumi_i)
`ifdef COUNTONES_GEN_LAST_EN
      ,
      .last_o  (last_o)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_passed = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act === exp) n_passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int sat(input int c);
      return (c > W) ? W : c;
   endfunction

   // Model: a word is just the list of bits still owed to the consumer.
   bit       exp_q[$];
   int       word_sat;
   int       nbits;
   bit [W-1:0] word;
   bit [W-1:0] last_word;
   int       words_done = 0;
   bit       seen_bit;

   always @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         exp_q.delete();
         nbits = 0;
         word  = '0;
      end else if (exp_q.size() != 0) begin
         if (yumi_i) begin
            word[nbits] = seen_bit;
            nbits++;
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
               check("loopback_ones", $countones(word), word_sat);
               check("loopback_thermo", int'(word), (1 << word_sat) - 1);
               last_word = word;
               words_done++;
               nbits = 0;
               word  = '0;
            end
         end
      end else if (valid_i) begin
         word_sat = sat(int'(count_i));
         for (int i = 0; i < W; i++) exp_q.push_back(i < word_sat);
      end
   end

   always @(negedge clk) begin
      seen_bit = bit_o;
      check("valid_o", int'(valid_o), int'(exp_q.size() != 0));
      check("ready_o", int'(ready_o), int'(exp_q.size() == 0));
      check("bit_o", int'(bit_o), (exp_q.size() != 0) ? int'(exp_q[0]) : 0);
`ifdef COUNTONES_GEN_LAST_EN
      check("last_o", int'(last_o), int'(exp_q.size() == 1));
`endif
   end

   task automatic run_word(input int cnt, input int exp_word, input bit stall,
                           input bit poke, input string name);
      int k;
      int start;
      k = 0;
      while (!ready_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      start   = words_done;
      valid_i = 1'b1;
      count_i = CW'(cnt);
      @(negedge clk);
      valid_i = 1'b0;
      k = 0;
      while (words_done == start && k < 200) begin
         yumi_i = valid_o && (!stall || (k % 3 == 0));
         if (poke) begin
            valid_i = 1'($urandom);
            count_i = CW'($urandom);
         end
         @(negedge clk);
         k++;
      end
      yumi_i  = 1'b0;
      valid_i = 1'b0;
      if (words_done == start) check({name, "_timeout"}, 1, 0);
      else check(name, int'(last_word), exp_word);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      reset_i = 1'b1;
      valid_i = 1'b1;
      count_i = CW'(3);
      yumi_i  = 1'b0;
      #1;
      check("reset_ready", int'(ready_o), 1);
      check("reset_valid", int'(valid_o), 0);
      check("reset_bit", int'(bit_o), 0);
      @(negedge clk);
      @(negedge clk);
      reset_i = 1'b0;
      valid_i = 1'b0;
      @(negedge clk);

      run_word(3, 8'b0000_0111, 1'b0, 1'b0, "word_c3");
      run_word(0, 8'h00, 1'b0, 1'b0, "word_c0");
      run_word(8, 8'hFF, 1'b0, 1'b0, "word_c8");
      run_word(13, 8'hFF, 1'b0, 1'b0, "word_c13_sat");
      run_word(5, 8'b0001_1111, 1'b1, 1'b1, "word_c5_stall");

      // Abort a word after three bits; reset must act without a clock edge.
      valid_i = 1'b1;
      count_i = CW'(6);
      @(negedge clk);
      valid_i = 1'b0;
      yumi_i  = 1'b1;
      repeat (3) @(negedge clk);
      yumi_i = 1'b0;
      #1 reset_i = 1'b1;
      #1;
      check("async_reset_valid", int'(valid_o), 0);
      check("async_reset_ready", int'(ready_o), 1);
      check("async_reset_bit", int'(bit_o), 0);
      @(negedge clk);
      reset_i = 1'b0;
      @(negedge clk);
      run_word(2, 8'b0000_0011, 1'b0, 1'b0, "word_c2_after_reset");

      for (int c = 0; c <= W; c++) run_word(c, (1 << c) - 1, 1'b0, 1'b0, "loop_sweep");

      for (int n = 0; n < 3000; n++) begin
         valid_i = 1'($urandom);
         count_i = CW'($urandom);
         yumi_i  = valid_o && ($urandom_range(3) != 0);
         @(negedge clk);
      end
      valid_i = 1'b0;
      k = 0;
      while (valid_o && k < 100) begin
         yumi_i = 1'b1;
         @(negedge clk);
         k++;
      end
      yumi_i = 1'b0;
      check("drain_idle", int'(valid_o), 0);

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule

// File: doc/countones_gen.md
Name: countones_gen

Overview:
- Inverse of `countones`: takes a population count and serially emits a `width_p`-bit word containing exactly that many ones, LSB first, as a thermometer pattern (ones first, then zeros).
- Serves as a stimulus source for the `countones` datapath.
- Loopback target: deserialise its output, feed it back into `countones`, and recover the original count.
- Input side uses a valid/ready handshake; output side uses a valid/yumi handshake.

Parameters:
- `width_p`, default 8, number of bits in each emitted word. Must be >= 2.
- `count_width_lp` (localparam), equal to $clog2(width_p)+1, width of the count field. This matches the `countones` `count_o` width.

Ports:
- `clk_i`  input  1  clock; all state changes on the rising edge.
- `reset_i`  input  1  asynchronous, active-high reset.
- `valid_i`  input  1  `count_i` is valid.
- `count_i`  input  `count_width_lp`  requested number of ones.
- `ready_o`  output  1  block can accept a count.
- `valid_o`  output  1  `bit_o` is valid.
- `bit_o`  output  1  current serial bit.
- `yumi_i`  input  1  consumer takes `bit_o` this cycle. Only meaningful while `valid_o` is high.

Behaviour:
- Interface rule: one clock (`clk_i`); reset (`reset_i`) is asynchronous and active-high.
- Reset values, applied immediately on `reset_i` assertion without waiting for a clock edge:
  - state = IDLE
  - `ready_o` = 1, `valid_o` = 0, `bit_o` = 0
  - index = 0, stored count = 0
- States: IDLE and SHIFT.
- IDLE:
  - `ready_o` = 1, `valid_o` = 0, `bit_o` = 0.
  - When `valid_i` and `ready_o` are both high at a clock edge:
    - latch the count, saturated: a value greater than `width_p` is stored as `width_p`;
    - index = 0;
    - move to SHIFT.
- SHIFT:
  - `ready_o` = 0, `valid_o` = 1.
  - `bit_o` = (index < stored count). This is combinational from registered state; no output registers.
  - `yumi_i` high at a clock edge: index advances by one.
  - `yumi_i` high and index == `width_p`-1: return to IDLE and clear index.
  - `yumi_i` low: hold index and `bit_o`. Stalls of any length are legal.
- Latency:
  - Accept edge to first valid bit: 1 cycle.
  - Full word with `yumi_i` held high: `width_p` cycles.
  - One IDLE bubble cycle between words. A new count is never accepted in the same cycle as the last bit.
- Boundaries:
  - count = 0: all `width_p` bits are 0.
  - count = `width_p`: all bits are 1.
  - `valid_i` while in SHIFT: ignored, no latch.
  - `yumi_i` while `valid_o` = 0: ignored.
  - Index compare: width `count_width_lp`, unsigned, no wrap. The index never exceeds `width_p`-1.
- Reset mid-word: immediate abort with no partial-word completion. After deassertion the block is in IDLE with `ready_o` = 1.
- Internal assertions (simulation only):
  - `yumi_i` implies `valid_o`.
  - index < `width_p` whenever in SHIFT.
  - total ones emitted per word equals the saturated count.

Optional Feature:
- Macro: `COUNTONES_GEN_LAST_EN`.
- Defined:
  - adds output port `last_o` (1 bit), high during SHIFT when index == `width_p`-1;
  - reset value 0; 0 in IDLE.
  - Lets the consumer frame words without counting.
- Not defined: port absent; behaviour otherwise identical.

Decomposition:
- Package `countones_pkg`:
  - state enum `countones_gen_state_e` (`eIDLE`, `eSHIFT`);
  - function computing count width from `width_p`, shared with `countones`.
- One sub-module is natural: `countones_gen_ctr`. It is a saturating up-counter with clear and enable, and holds the bit index.
- Everything else is flat in `countones_gen`.

Test Plan:
- Reset released, `valid_i`=1, `count_i`=3, `yumi_i` held 1 -> `ready_o` drops next cycle; `bit_o` sequence 1,1,1,0,0,0,0,0 over 8 cycles; `ready_o`=1 on the following cycle.
- `count_i`=0 -> eight 0 bits; then `count_i`=8 -> eight 1 bits; exactly one `ready_o` bubble between words.
- `count_i`=13 (saturation) -> eight 1 bits; assertion-checked ones count = 8.
- `count_i`=5 with `yumi_i` toggling 1,0,0,1,... -> `bit_o` holds during stalls; bits consumed = 1,1,1,1,1,0,0,0; `valid_i` pulses during SHIFT are ignored.
- `count_i`=6, assert `reset_i` asynchronously after 3 bits consumed -> `valid_o`=0 and `ready_o`=1 immediately without a clock edge; a next count of 2 yields 1,1,0,0,0,0,0,0.
- Loopback: every count 0..8 -> deserialise to 8 bits, feed `countones` -> `count_o` equals input; with `COUNTONES_GEN_LAST_EN`, `last_o` high only on the 8th bit.
